// File: rtl/pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// pll_reset_sequencer
//
// Drives the PLL reset, watches the PLL lock indication and releases the
// system reset only after lock has been continuously stable for a programmable
// number of reference-clock cycles. Lock loss while running, or failure to
// reach a stable lock within a timeout window, automatically re-resets the PLL.
// Runs on the board reference clock so it keeps working while the PLL output
// clocks are stopped.
//
// Parameters
//   PLL_RST_CYCLES      cycles pll_rst is held high per attempt (>= 1)
//   LOCK_STABLE_CYCLES  cycles locked must stay high before release (>= 1)
//   LOCK_TIMEOUT_CYCLES max cycles in WAIT_LOCK+STABLE before a retry
//                       (> LOCK_STABLE_CYCLES)
//
// Ports
//   refclk         in   reference clock, the only clock
//   rst_n          in   asynchronous active-low reset
//   locked         in   PLL lock, asynchronous to refclk (2-flop synchronized)
//   restart        in   single-cycle request to re-run the full sequence
//   pll_rst        out  active-high reset to the PLL
//   sys_rst_n      out  active-low system reset request
//   ready          out  high while in RUN
//   state          out  PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3
//   lock_loss_cnt  out  RUN->PLL_RST transitions due to lock loss (sat. 255)
//   retry_cnt      out  lock-acquisition timeouts (sat. 15)
// -----------------------------------------------------------------------------
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       ready,
  output logic [1:0] state,
  output logic [7:0] lock_loss_cnt,
  output logic [3:0] retry_cnt
);

  // One counter width serves both cycle counters; sized for the largest
  // parameter so any combination of parameters fits.
  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                           PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_CYC = (MAX_AB > LOCK_TIMEOUT_CYCLES) ?
                           MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] PRST_LAST   = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    S_PLL_RST   = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_e;

  // Synchronizer
  logic             lock_meta_q;
  logic             locked_s_q;

  // FSM and counters
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [CNT_W-1:0] tcnt_q,  tcnt_d;
  logic [7:0]       llc_q,   llc_d;
  logic [3:0]       retry_q, retry_d;

  // Registered Moore outputs, loaded from the next state so they always
  // match a decode of state_q without any combinational output path.
  logic             pll_rst_q;
  logic             ready_q;

  logic             to_run;
  logic             timeout;
  logic             lock_lost;

  always_comb begin
    state_d   = state_q;
    lock_lost = 1'b0;

    // Reaching the end of the stability window wins over a timeout that
    // would expire on the same cycle.
    to_run  = (state_q == S_STABLE) && locked_s_q && (cnt_q == STABLE_LAST);
    timeout = ((state_q == S_WAIT_LOCK) || (state_q == S_STABLE)) &&
              (tcnt_q == TMO_LAST) && !to_run;

    if (restart) begin
      state_d = S_PLL_RST;
    end else if (timeout) begin
      state_d = S_PLL_RST;
    end else begin
      case (state_q)
        S_PLL_RST: begin
          if (cnt_q == PRST_LAST) state_d = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (locked_s_q) state_d = S_STABLE;
        end
        S_STABLE: begin
          // Any drop restarts the stability window from WAIT_LOCK.
          if (!locked_s_q)  state_d = S_WAIT_LOCK;
          else if (to_run)  state_d = S_RUN;
        end
        S_RUN: begin
          if (!locked_s_q) begin
            state_d   = S_PLL_RST;
            lock_lost = 1'b1;
          end
        end
        default: state_d = S_PLL_RST;
      endcase
    end

    // cnt measures time in the current state. A restart while already in
    // PLL_RST has no state change but must still restart the count.
    if (restart || (state_d != state_q)) begin
      cnt_d = '0;
    end else if ((state_q == S_PLL_RST) || (state_q == S_STABLE)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = '0;
    end

    // tcnt spans WAIT_LOCK and STABLE together (bouncing between them does
    // not reset it); it is held at zero outside that window.
    if ((state_d == S_PLL_RST) || (state_q == S_PLL_RST) || (state_q == S_RUN)) begin
      tcnt_d = '0;
    end else begin
      tcnt_d = tcnt_q + CNT_ONE;
    end

    llc_d = llc_q;
    if (lock_lost && (llc_q != 8'hFF)) llc_d = llc_q + 8'd1;

    retry_d = retry_q;
    if (timeout && !restart && (retry_q != 4'hF)) retry_d = retry_q + 4'd1;
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_q <= 1'b0;
      locked_s_q  <= 1'b0;
      state_q     <= S_PLL_RST;
      cnt_q       <= '0;
      tcnt_q      <= '0;
      llc_q       <= 8'd0;
      retry_q     <= 4'd0;
      pll_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      lock_meta_q <= locked;
      locked_s_q  <= lock_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tcnt_q      <= tcnt_d;
      llc_q       <= llc_d;
      retry_q     <= retry_d;
      pll_rst_q   <= (state_d == S_PLL_RST);
      ready_q     <= (state_d == S_RUN);
    end
  end

  assign pll_rst       = pll_rst_q;
  assign sys_rst_n     = ready_q;
  assign ready         = ready_q;
  assign state         = state_q;
  assign lock_loss_cnt = llc_q;
  assign retry_cnt     = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_sequencer
//
// Self-checking bench for pll_reset_sequencer with PLL_RST_CYCLES=4,
// LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32. Inputs change on the falling
// edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_pll_reset_sequencer;

  localparam int PR = 4;
  localparam int LS = 8;
  localparam int TO = 32;

  logic       refclk;
  logic       rst_n;
  logic       locked;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  logic [1:0] state;
  logic [7:0] lock_loss_cnt;
  logic [3:0] retry_cnt;

  int total = 0;
  int bad   = 0;

  // Reference model: plain integers describing the sequencer's rules.
  int m_state, m_age, m_wait, m_llc, m_retry;
  bit m_meta, m_ls;

  pll_reset_sequencer #(
    .PLL_RST_CYCLES     (PR),
    .LOCK_STABLE_CYCLES (LS),
    .LOCK_TIMEOUT_CYCLES(TO)
  ) dut (
    .refclk       (refclk),
    .rst_n        (rst_n),
    .locked       (locked),
    .restart      (restart),
    .pll_rst      (pll_rst),
    .sys_rst_n    (sys_rst_n),
    .ready        (ready),
    .state        (state),
    .lock_loss_cnt(lock_loss_cnt),
    .retry_cnt    (retry_cnt)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  typedef struct {
    logic lk;
    logic rs;
    int   n;
    int   st;
    int   pr;
    int   sr;
    int   rd;
    int   llc;
    int   rc;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input int st, input int pr,
                            input int sr, input int rd, input int llc, input int rc);
    chk({name, ".state"},     int'(state),         st);
    chk({name, ".pll_rst"},   int'(pll_rst),       pr);
    chk({name, ".sys_rst_n"}, int'(sys_rst_n),     sr);
    chk({name, ".ready"},     int'(ready),         rd);
    chk({name, ".lock_loss"}, int'(lock_loss_cnt), llc);
    chk({name, ".retry"},     int'(retry_cnt),     rc);
  endtask

  task automatic model_reset();
    m_state = 0; m_age = 0; m_wait = 0; m_llc = 0; m_retry = 0;
    m_meta  = 1'b0; m_ls = 1'b0;
  endtask

  // One rising edge of the reference behaviour.
  task automatic model_step();
    int nxt;
    bit to_run;
    bit tmo;
    nxt    = m_state;
    to_run = (m_state == 2) && m_ls && (m_age == LS - 1);
    tmo    = ((m_state == 1) || (m_state == 2)) && (m_wait == TO - 1) && !to_run;
    if (restart) begin
      nxt = 0;
    end else if (tmo) begin
      nxt = 0;
      m_retry = (m_retry < 15) ? m_retry + 1 : 15;
    end else begin
      case (m_state)
        0: if (m_age == PR - 1) nxt = 1;
        1: if (m_ls) nxt = 2;
        2: if (!m_ls) nxt = 1; else if (to_run) nxt = 3;
        default: if (!m_ls) begin
          nxt = 0;
          m_llc = (m_llc < 255) ? m_llc + 1 : 255;
        end
      endcase
    end
    if ((nxt == 1) || (nxt == 2)) m_wait = (m_state == 0) ? 0 : m_wait + 1;
    else                          m_wait = 0;
    m_age   = (restart || (nxt != m_state)) ? 0 : m_age + 1;
    m_ls    = m_meta;
    m_meta  = locked;
    m_state = nxt;
  endtask

  task automatic check_model(input string name);
    check_outs(name, m_state, (m_state == 0) ? 1 : 0, (m_state == 3) ? 1 : 0,
               (m_state == 3) ? 1 : 0, m_llc, m_retry);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge refclk);
      model_step();
      @(negedge refclk);
    end
  endtask

  // Called at a falling edge; releases reset at the following falling edge.
  task automatic do_reset(input logic lk);
    locked  = lk;
    restart = 1'b0;
    rst_n   = 1'b0;
    model_reset();
    @(negedge refclk);
    rst_n = 1'b1;
  endtask

  initial begin
    // {locked, restart, cycles, state, pll_rst, sys_rst_n, ready, llc, retry}
    tbl[0]  = '{1'b0, 1'b0, 3, 0, 1, 0, 0, 0, 0};
    tbl[1]  = '{1'b0, 1'b0, 1, 1, 0, 0, 0, 0, 0};
    tbl[2]  = '{1'b1, 1'b0, 1, 1, 0, 0, 0, 0, 0};
    tbl[3]  = '{1'b1, 1'b0, 1, 1, 0, 0, 0, 0, 0};
    tbl[4]  = '{1'b1, 1'b0, 1, 2, 0, 0, 0, 0, 0};
    tbl[5]  = '{1'b1, 1'b0, 7, 2, 0, 0, 0, 0, 0};
    tbl[6]  = '{1'b1, 1'b0, 1, 3, 0, 1, 1, 0, 0};
    tbl[7]  = '{1'b0, 1'b0, 1, 3, 0, 1, 1, 0, 0};
    tbl[8]  = '{1'b0, 1'b0, 1, 3, 0, 1, 1, 0, 0};
    tbl[9]  = '{1'b0, 1'b0, 1, 0, 1, 0, 0, 1, 0};
    tbl[10] = '{1'b1, 1'b0, 3, 0, 1, 0, 0, 1, 0};
    tbl[11] = '{1'b1, 1'b0, 1, 1, 0, 0, 0, 1, 0};
    tbl[12] = '{1'b1, 1'b0, 1, 2, 0, 0, 0, 1, 0};
    tbl[13] = '{1'b1, 1'b0, 8, 3, 0, 1, 1, 1, 0};
    tbl[14] = '{1'b1, 1'b1, 1, 0, 1, 0, 0, 1, 0};
    tbl[15] = '{1'b1, 1'b0, 4, 1, 0, 0, 0, 1, 0};
    tbl[16] = '{1'b1, 1'b0, 1, 2, 0, 0, 0, 1, 0};

    locked  = 1'b0;
    restart = 1'b0;
    rst_n   = 1'b0;
    model_reset();
    #12;
    check_outs("reset", 0, 1, 0, 0, 0, 0);
    @(negedge refclk);
    rst_n = 1'b1;

    // Power-up, clean lock, lock loss, relock, restart in RUN.
    for (int i = 0; i < 17; i++) begin
      locked  = tbl[i].lk;
      restart = tbl[i].rs;
      tick(tbl[i].n);
      check_outs($sformatf("vec%0d", i), tbl[i].st, tbl[i].pr, tbl[i].sr,
                 tbl[i].rd, tbl[i].llc, tbl[i].rc);
    end
    restart = 1'b0;

    // Unstable lock: a 2-cycle drop mid-window forces a full new window.
    do_reset(1'b1);
    tick(9);
    check_outs("unst_mid", 2, 0, 0, 0, 0, 0);
    locked = 1'b0;
    tick(2);
    locked = 1'b1;
    tick(1);
    check_outs("unst_back", 1, 0, 0, 0, 0, 0);
    tick(1);
    check_outs("unst_wait", 1, 0, 0, 0, 0, 0);
    tick(1);
    check_outs("unst_restab", 2, 0, 0, 0, 0, 0);
    tick(7);
    check_outs("unst_full", 2, 0, 0, 0, 0, 0);
    tick(1);
    check_outs("unst_run", 3, 0, 1, 1, 0, 0);

    // Timeout and retry counter saturation.
    do_reset(1'b0);
    tick(PR - 1 + TO);
    check_outs("tmo_edge", 1, 0, 0, 0, 0, 0);
    tick(1);
    check_outs("tmo_fire", 0, 1, 0, 0, 0, 1);
    tick((PR + TO) * 13);
    check_outs("tmo_14", 0, 1, 0, 0, 0, 14);
    tick(PR + TO);
    check_outs("tmo_15", 0, 1, 0, 0, 0, 15);
    tick((PR + TO) * 5);
    check_outs("tmo_sat", 0, 1, 0, 0, 0, 15);

    // Restart in RUN leaves counters alone; restart in PLL_RST restarts count.
    locked = 1'b1;
    tick(PR + 1 + LS);
    check_outs("rs_run", 3, 0, 1, 1, 0, 15);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    check_outs("rs_pulse", 0, 1, 0, 0, 0, 15);
    tick(2);
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    tick(3);
    check_outs("rs_recount", 0, 1, 0, 0, 0, 15);
    tick(1);
    check_outs("rs_wait", 1, 0, 0, 0, 0, 15);

    // Asynchronous reset mid-STABLE.
    tick(3);
    check_outs("ar_stable", 2, 0, 0, 0, 0, 15);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outs("ar_async", 0, 1, 0, 0, 0, 0);
    @(negedge refclk);
    check_outs("ar_held", 0, 1, 0, 0, 0, 0);
    rst_n = 1'b1;

    // Randomized traffic against the reference model.
    locked = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      int rate;
      rate = (((i / 500) % 3) == 0) ? 5 : ((((i / 500) % 3) == 1) ? 20 : 60);
      if ($urandom_range(0, rate - 1) == 0) locked = ~locked;
      restart = ($urandom_range(0, 149) == 0);
      tick(1);
      check_model("rnd");
    end
    restart = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
